// File: rtl/switch_output_arbiter.sv
// Output-port scheduler for a BFT t_switch: per-output round-robin with a starvation override
// and backpressure, producing crossbar selects and input-FIFO pop strobes.
module switch_output_arbiter #(
  parameter int STARVE_LIMIT = 15,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] d_l,
  input  logic [1:0] d_r,
  input  logic [1:0] d_u,
  input  logic [2:0] out_ready,
  output logic [2:0] in_ack,
  output logic [1:0] sel_l,
  output logic [1:0] sel_r,
  output logic [1:0] sel_u,
  output logic [2:0] out_valid,
  output logic       turn_err
);

  localparam logic [1:0] DIR_VOID = 2'b00;
  localparam logic [1:0] SEL_NONE = 2'd3;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] STARVE_TH = CNT_W'(STARVE_LIMIT);

  logic [1:0]       d        [3];
  logic [1:0]       rr_ptr   [3];
  logic [CNT_W-1:0] wait_cnt [3];
  logic [2:0]       cand     [3];
  logic [1:0]       gnt_idx  [3];
  logic [2:0]       gnt_vld;
  logic [2:0]       gnt_any;
  logic [2:0]       illegal;
  logic [2:0]       idle;

  assign d[0] = d_l;
  assign d[1] = d_r;
  assign d[2] = d_u;

  // Direction code of port n is n+1 (LEFT=1, RIGHT=2, UP=3); VOID is 0.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      illegal[i] = (d[i] == 2'(i + 1));
      idle[i]    = (d[i] == DIR_VOID);
    end
    for (int o = 0; o < 3; o++) begin
      for (int i = 0; i < 3; i++) begin
        cand[o][i] = (i != o) && (d[i] == 2'(o + 1));
      end
    end
  end

  // Per-output arbitration; descending scans leave the lowest-priority-order winner last.
  always_comb begin
    logic [2:0] sum;
    logic [1:0] j;
    sum = '0;
    j   = '0;
    for (int o = 0; o < 3; o++) begin
      gnt_vld[o] = 1'b0;
      gnt_idx[o] = SEL_NONE;
      if (out_ready[o]) begin
        for (int i = 2; i >= 0; i--) begin
          if (cand[o][i] && (wait_cnt[i] >= STARVE_TH)) begin
            gnt_vld[o] = 1'b1;
            gnt_idx[o] = 2'(i);
          end
        end
        if (!gnt_vld[o]) begin
          for (int k = 2; k >= 0; k--) begin
            sum = {1'b0, rr_ptr[o]} + 3'(k);
            j   = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (cand[o][j]) begin
              gnt_vld[o] = 1'b1;
              gnt_idx[o] = j;
            end
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      gnt_any[i] = 1'b0;
      for (int o = 0; o < 3; o++) begin
        if (gnt_vld[o] && (gnt_idx[o] == 2'(i))) gnt_any[i] = 1'b1;
      end
    end
  end

  assign in_ack = reset ? 3'b000 : gnt_any;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_l     <= SEL_NONE;
      sel_r     <= SEL_NONE;
      sel_u     <= SEL_NONE;
      out_valid <= 3'b000;
      turn_err  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        rr_ptr[i]   <= 2'd0;
        wait_cnt[i] <= '0;
      end
    end else begin
      sel_l     <= gnt_idx[0];
      sel_r     <= gnt_idx[1];
      sel_u     <= gnt_idx[2];
      out_valid <= gnt_vld;
      if (|illegal) turn_err <= 1'b1;
      for (int o = 0; o < 3; o++) begin
        if (gnt_vld[o]) rr_ptr[o] <= (gnt_idx[o] == 2'd2) ? 2'd0 : gnt_idx[o] + 2'd1;
      end
      // Illegal requesters keep their count so a later legal request is not penalised.
      for (int i = 0; i < 3; i++) begin
        if (gnt_any[i] || idle[i]) wait_cnt[i] <= '0;
        else if (!illegal[i] && (wait_cnt[i] != CNT_MAX)) wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_switch_output_arbiter.sv
// Scoreboarded bench for switch_output_arbiter: directed scenarios then randomized traffic,
// predicted by a behavioural model of the arbitration rules.
module tb_switch_output_arbiter;

  localparam int LIM = 3;
  localparam int SAT = 15;
  localparam logic [1:0] V = 2'd0, L = 2'd1, R = 2'd2, U = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] d_l, d_r, d_u;
  logic [2:0] out_ready;
  logic [2:0] in_ack;
  logic [1:0] sel_l, sel_r, sel_u;
  logic [2:0] out_valid;
  logic       turn_err;

  always #5 clk = ~clk;

  switch_output_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .d_l(d_l), .d_r(d_r), .d_u(d_u), .out_ready(out_ready),
    .in_ack(in_ack), .sel_l(sel_l), .sel_r(sel_r), .sel_u(sel_u),
    .out_valid(out_valid), .turn_err(turn_err)
  );

  typedef struct { int tag; logic [2:0] ack; } ack_t;
  typedef struct { int tag; logic [1:0] s0, s1, s2; logic [2:0] ov; logic te; } reg_t;

  ack_t ack_q[$];
  reg_t reg_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  int m_ptr[3];
  int m_w[3];
  int m_sel[3];
  logic [2:0] m_ov;
  logic m_te;
  logic [2:0] m_ack;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input int tag, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, tag, act, exp);
    end
  endtask

  // Monitor: in_ack for the inputs of this cycle, registered outputs from the previous cycle.
  initial begin
    forever begin
      ack_t a;
      reg_t r;
      @(negedge clk);
      while (ack_q.size() > 0 && ack_q[0].tag <= cyc) begin
        a = ack_q.pop_front();
        check("in_ack", a.tag, {5'd0, in_ack}, {5'd0, a.ack});
      end
      while (reg_q.size() > 0 && reg_q[0].tag <= cyc) begin
        r = reg_q.pop_front();
        check("sel_l", r.tag, {6'd0, sel_l}, {6'd0, r.s0});
        check("sel_r", r.tag, {6'd0, sel_r}, {6'd0, r.s1});
        check("sel_u", r.tag, {6'd0, sel_u}, {6'd0, r.s2});
        check("out_valid", r.tag, {5'd0, out_valid}, {5'd0, r.ov});
        check("turn_err", r.tag, {7'd0, turn_err}, {7'd0, r.te});
      end
    end
  end

  function automatic reg_t snap(input int tag);
    reg_t r;
    r.tag = tag;
    r.s0 = 2'(m_sel[0]);
    r.s1 = 2'(m_sel[1]);
    r.s2 = 2'(m_sel[2]);
    r.ov = m_ov;
    r.te = m_te;
    return r;
  endfunction

  // Drive one cycle of inputs and push the model's predictions for it.
  task automatic step(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                      input logic [2:0] rdy, input logic rs);
    int d[3];
    int n;
    int best;
    int j;
    @(posedge clk);
    #1;
    reset = rs; d_l = a; d_r = b; d_u = c; out_ready = rdy;
    n = cyc;
    d[0] = int'(a); d[1] = int'(b); d[2] = int'(c);
    m_ack = 3'b000;
    if (rs) begin
      for (int i = 0; i < 3; i++) begin
        m_ptr[i] = 0; m_w[i] = 0; m_sel[i] = 3;
      end
      m_ov = 3'b000;
      m_te = 1'b0;
      reg_q.delete();
      reg_q.push_back(snap(n));
      reg_q.push_back(snap(n + 1));
    end else begin
      for (int o = 0; o < 3; o++) begin
        best = -1;
        if (rdy[o]) begin
          for (int i = 0; i < 3; i++)
            if (best < 0 && i != o && d[i] == o + 1 && m_w[i] >= LIM) best = i;
          for (int k = 0; k < 3; k++) begin
            j = (m_ptr[o] + k) % 3;
            if (best < 0 && j != o && d[j] == o + 1) best = j;
          end
        end
        if (best >= 0) begin
          m_ack[best] = 1'b1;
          m_sel[o] = best;
          m_ov[o] = 1'b1;
          m_ptr[o] = (best + 1) % 3;
        end else begin
          m_sel[o] = 3;
          m_ov[o] = 1'b0;
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (d[i] == i + 1) m_te = 1'b1;
        if (m_ack[i] || d[i] == 0) m_w[i] = 0;
        else if (d[i] != i + 1) m_w[i] = (m_w[i] + 1 > SAT) ? SAT : m_w[i] + 1;
      end
      reg_q.push_back(snap(n + 1));
    end
    ack_q.push_back('{tag: n, ack: m_ack});
  endtask

  initial begin
    logic [1:0] hd[3];
    logic [1:0] nd;
    logic [2:0] rdy;
    reset = 1'b1; d_l = U; d_r = V; d_u = V; out_ready = 3'b111;
    for (int i = 0; i < 3; i++) begin
      m_ptr[i] = 0; m_w[i] = 0; m_sel[i] = 3;
    end
    m_ov = 3'b000; m_te = 1'b0; m_ack = 3'b000;

    // reset with a pending request, then release
    step(U, V, V, 3'b111, 1'b1);
    step(U, V, V, 3'b111, 1'b1);
    step(U, V, V, 3'b111, 1'b0);
    step(V, V, V, 3'b111, 1'b1);
    // contention for U
    repeat (4) step(U, U, V, 3'b111, 1'b0);
    // backpressure on R, then release
    repeat (5) step(R, V, V, 3'b101, 1'b0);
    step(R, V, V, 3'b111, 1'b0);
    // starvation: U waits on L while blocked, then beats R
    repeat (3) step(V, V, L, 3'b110, 1'b0);
    step(V, L, L, 3'b111, 1'b0);
    step(V, L, V, 3'b111, 1'b0);
    // full parallel permutation
    step(R, U, L, 3'b111, 1'b0);
    step(V, V, V, 3'b111, 1'b0);
    // illegal turn is sticky until reset
    step(V, R, V, 3'b111, 1'b0);
    repeat (3) step(V, V, V, 3'b111, 1'b0);
    step(V, V, V, 3'b111, 1'b1);

    for (int i = 0; i < 3; i++) hd[i] = V;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < 3; i++) begin
        if (hd[i] == V || m_ack[i] || hd[i] == 2'(i + 1) || $urandom_range(0, 19) == 0) begin
          nd = 2'($urandom_range(0, 3));
          if (nd == 2'(i + 1) && $urandom_range(0, 19) != 0) nd = V;
          hd[i] = nd;
        end
      end
      rdy = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      step(hd[0], hd[1], hd[2], rdy, ($urandom_range(0, 199) == 0));
    end
    step(V, V, V, 3'b111, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("queue_drain", cyc, 8'(ack_q.size() + reg_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
